// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner.
// Repeat FSM encodings and released raw levels of each button.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  localparam logic START_REL = 1'b0;
  localparam logic NEXTN_REL = 1'b1;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchronizer, counter debounce,
// press-edge detect. REL_LVL is the raw released level (1 = active-low).
module debounce_channel #(
  parameter int   DEBOUNCE_CYCLES = 250,
  parameter int   CNT_W           = 16,
  parameter logic REL_LVL         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic db,
  output logic press_p
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             lvl;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  // active-high pressed level after synchronization
  assign lvl = s2 ^ REL_LVL;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1       <= REL_LVL;
      s2       <= REL_LVL;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw_in;
      s2       <= s1;
      stable_q <= stable;
      if (lvl == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= lvl;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign db      = stable;
  assign press_p = stable & ~stable_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the start and next buttons for babbage:
// debounced levels, press pulses, auto-repeat on next.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start_raw,
  input  logic nextn_raw,
  output logic start_p,
  output logic next_p,
  output logic start_db,
  output logic next_db
);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  rpt_state_t       st;
  logic [CNT_W-1:0] rcnt;
  logic             next_press;
  logic             rpt_fire;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .REL_LVL        (START_REL)
  ) u_start (
    .clk    (clk),
    .rst    (rst),
    .raw_in (start_raw),
    .db     (start_db),
    .press_p(start_p)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .REL_LVL        (NEXTN_REL)
  ) u_next (
    .clk    (clk),
    .rst    (rst),
    .raw_in (nextn_raw),
    .db     (next_db),
    .press_p(next_press)
  );

  // gated by next_db so the release cycle never repeats
  assign rpt_fire = next_db &&
    ((st == RPT_DELAY  && rcnt == DLY_LAST) ||
     (st == RPT_REPEAT && rcnt == PER_LAST));

  always_ff @(posedge clk) begin
    if (!rst) begin
      st   <= RPT_IDLE;
      rcnt <= '0;
    end else if (!next_db) begin
      st   <= RPT_IDLE;
      rcnt <= '0;
    end else begin
      unique case (st)
        RPT_IDLE: begin
          rcnt <= '0;
          if (next_press && REPEAT_EN)
            st <= RPT_DELAY;
        end
        RPT_DELAY: begin
          if (rcnt == DLY_LAST) begin
            st   <= RPT_REPEAT;
            rcnt <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (rcnt == PER_LAST)
            rcnt <= '0;
          else
            rcnt <= rcnt + 1'b1;
        end
        default: begin
          st   <= RPT_IDLE;
          rcnt <= '0;
        end
      endcase
    end
  end

  assign next_p = next_press | rpt_fire;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random
// button activity against a run-length reference model.
module tb_button_conditioner;

  localparam int DC   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_raw = 1'b0;
  logic nextn_raw = 1'b1;
  logic start_p, next_p, start_db, next_db;
  logic start_p0, next_p0, start_db0, next_db0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .REPEAT_EN(1'b1), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .start_raw(start_raw), .nextn_raw(nextn_raw),
    .start_p(start_p), .next_p(next_p),
    .start_db(start_db), .next_db(next_db)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .REPEAT_EN(1'b0), .CNT_W(8)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start_raw(start_raw), .nextn_raw(nextn_raw),
    .start_p(start_p0), .next_p(next_p0),
    .start_db(start_db0), .next_db(next_db0)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int hold_st = -1;
  int t0;
  bit raw_s[MAXC];
  bit raw_n[MAXC];
  bit rs[MAXC];
  bit m_dbs[MAXC];
  bit m_dbn[MAXC];
  int sp_q[$];
  int np_q[$];
  int np0_q[$];
  int t3e[6] = '{6, 16, 19, 22, 25, 28};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h",
                  tag, cyc, got, exp);
  endtask

  function automatic bit rst_at(input int i);
    return (i < 0) ? 1'b0 : rs[i];
  endfunction

  // pressed level seen after the two sync flops in cycle k
  function automatic bit sync_at(input int k, input bit nch);
    if (!rst_at(k - 1) || !rst_at(k - 2)) return 1'b0;
    return nch ? ~raw_n[k-2] : raw_s[k-2];
  endfunction

  // level flips only after DC consecutive differing samples
  function automatic bit db_at(input int c, input bit nch);
    bit prev;
    bit flip;
    if (!rst_at(c - 1)) return 1'b0;
    prev = nch ? m_dbn[c-1] : m_dbs[c-1];
    flip = 1'b1;
    for (int j = 1; j <= DC; j++)
      if (sync_at(c - j, nch) == prev) flip = 1'b0;
    return flip ? ~prev : prev;
  endfunction

  task automatic eval_and_check();
    int c;
    bit ps, pn, rp;
    c = cyc;
    m_dbs[c] = db_at(c, 1'b0);
    m_dbn[c] = db_at(c, 1'b1);
    ps = m_dbs[c] && !m_dbs[c-1];
    pn = m_dbn[c] && !m_dbn[c-1];
    if (!m_dbn[c]) hold_st = -1;
    else if (pn) hold_st = c;
    rp = (hold_st >= 0) && (c - hold_st >= RD) &&
         ((c - hold_st - RD) % RP == 0);
    chk("outs_rpt", {start_p, next_p, start_db, next_db},
        {ps, pn | rp, m_dbs[c], m_dbn[c]});
    chk("outs_norpt", {start_p0, next_p0, start_db0, next_db0},
        {ps, pn, m_dbs[c], m_dbn[c]});
  endtask

  task automatic tick(input bit s, input bit n, input bit r);
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    start_raw = s;
    nextn_raw = n;
    rst = r;
    raw_s[cyc] = s;
    raw_n[cyc] = n;
    rs[cyc] = r;
    @(posedge clk);
    #1;
    cyc++;
    if (start_p) sp_q.push_back(cyc);
    if (next_p) np_q.push_back(cyc);
    if (next_p0) np0_q.push_back(cyc);
    eval_and_check();
  endtask

  task automatic hold(input bit s, input bit n, input bit r, input int len);
    for (int i = 0; i < len; i++) tick(s, n, r);
  endtask

  function automatic int rel(input int q[$], input int k, input int base);
    return (k < q.size()) ? q[k] - base : -1;
  endfunction

  function automatic int count_below(input int q[$], input int base,
                                     input int lim);
    int n;
    n = 0;
    foreach (q[i]) if (q[i] - base < lim) n++;
    return n;
  endfunction

  initial begin
    @(posedge clk);
    #1;
    cyc = 0;
    m_dbs[0] = 1'b0;
    m_dbn[0] = 1'b0;
    hold(0, 1, 0, 3);
    hold(0, 1, 1, 5);

    // start press, hold, release
    sp_q.delete();
    t0 = cyc;
    hold(1, 1, 1, 20);
    hold(0, 1, 1, 5);
    chk("t1_rel5_db", start_db, 1);
    tick(0, 1, 1);
    chk("t1_rel6_db", start_db, 0);
    hold(0, 1, 1, 10);
    chk("t1_npulse", sp_q.size(), 1);
    chk("t1_pulse_at", rel(sp_q, 0, t0), 6);

    // bouncing start never accepted
    sp_q.delete();
    for (int i = 0; i < 15; i++) hold(i % 2 == 0, 1, 1, 2);
    hold(0, 1, 1, 10);
    chk("t2_npulse", sp_q.size(), 0);

    // next held: press then auto-repeat; EN=0 copy pulses once
    np_q.delete();
    np0_q.delete();
    t0 = cyc;
    hold(0, 0, 1, 30);
    hold(0, 1, 1, 15);
    chk("t3_count", count_below(np_q, t0, 30), 6);
    for (int k = 0; k < 6; k++) chk("t3_pulse", rel(np_q, k, t0), t3e[k]);
    chk("t3_last", np_q.size() > 0 ? np_q[$] - t0 : -1, 34);
    chk("t4_count", np0_q.size(), 1);
    chk("t4_pulse_at", rel(np0_q, 0, t0), 6);

    // both pressed together
    sp_q.delete();
    np_q.delete();
    t0 = cyc;
    hold(1, 0, 1, 12);
    hold(0, 1, 1, 12);
    chk("t5_start_at", rel(sp_q, 0, t0), 6);
    chk("t5_next_at", rel(np_q, 0, t0), 6);

    // reset while next held
    np_q.delete();
    t0 = cyc;
    hold(0, 0, 1, 12);
    hold(0, 0, 0, 2);
    hold(0, 0, 1, 16);
    hold(0, 1, 1, 12);
    chk("t6_count", count_below(np_q, t0, 30), 2);
    chk("t6_first", rel(np_q, 0, t0), 6);
    chk("t6_fresh", rel(np_q, 1, t0), 20);

    // random activity with glitches and occasional reset
    for (int seg = 0; seg < 110; seg++) begin
      if ($urandom_range(0, 24) == 0)
        hold($urandom_range(0, 1), $urandom_range(0, 1), 0,
             $urandom_range(1, 3));
      else if ($urandom_range(0, 3) == 0)
        hold($urandom_range(0, 1), $urandom_range(0, 1), 1,
             $urandom_range(1, 4));
      else
        hold($urandom_range(0, 1), $urandom_range(0, 1), 1,
             $urandom_range(5, 30));
    end
    hold(0, 1, 1, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d limit=%0d", cyc, MAXC);
    $fatal(1);
  end

endmodule
